// File: rtl/pixel_port_arbiter_pkg.sv
// Shared constants and types for the VGA pixel-port arbiter and its sub-blocks.
package pixel_port_arbiter_pkg;
   localparam int NUM_REQ    = 3;
   localparam int REQ_DRAW   = 0;
   localparam int REQ_RAM    = 1;
   localparam int REQ_CURSOR = 2;
   localparam int COLOUR_W   = 9;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   // One spare bit above the minimum so coordinates have headroom.
   function automatic int coord_w(input int extent);
      return $clog2(extent) + 1;
   endfunction
endpackage

// File: rtl/pixel_port_arbiter_if.sv
// Requester-side bus into the pixel-port arbiter and the VGA-side pixel outputs.
interface pixel_port_arbiter_if #(
   parameter int XW = 10,
   parameter int YW = 9
);
   import pixel_port_arbiter_pkg::*;

   logic [NUM_REQ-1:0]          iReq;
   logic [NUM_REQ-1:0]          iValid;
   logic [NUM_REQ*XW-1:0]       iX;
   logic [NUM_REQ*YW-1:0]       iY;
   logic [NUM_REQ*COLOUR_W-1:0] iColour;
   logic [NUM_REQ-1:0]          oGrant;
   logic [NUM_REQ-1:0]          oAccept;
   logic [XW-1:0]               oX_pixel;
   logic [YW-1:0]               oY_pixel;
   logic [COLOUR_W-1:0]         oColour;
   logic                        oPlot;
   logic                        oBusy;

   modport master (
      output iReq, iValid, iX, iY, iColour,
      input  oGrant, oAccept, oX_pixel, oY_pixel, oColour, oPlot, oBusy
   );

   modport slave (
      input  iReq, iValid, iX, iY, iColour,
      output oGrant, oAccept, oX_pixel, oY_pixel, oColour, oPlot, oBusy
   );
endinterface

// File: rtl/pixel_port_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: scans last+1, last+2, last+3 (mod 3).
module rr_pick3 (
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic [2:0] pick
);
   always_comb begin
      pick = 3'b000;
      case (last)
         2'd0: begin
            if      (req[1]) pick = 3'b010;
            else if (req[2]) pick = 3'b100;
            else if (req[0]) pick = 3'b001;
         end
         2'd1: begin
            if      (req[2]) pick = 3'b100;
            else if (req[0]) pick = 3'b001;
            else if (req[1]) pick = 3'b010;
         end
         default: begin
            if      (req[0]) pick = 3'b001;
            else if (req[1]) pick = 3'b010;
            else if (req[2]) pick = 3'b100;
         end
      endcase
   end
endmodule

// File: rtl/pixel_port_arbiter.sv
// Burst-owning round-robin arbiter for the single VGA pixel-write port,
// with a burst cap so a long restore cannot starve the cursor.
module pixel_port_arbiter
   import pixel_port_arbiter_pkg::*;
#(
   parameter int SCREEN_WIDTH  = 320,
   parameter int SCREEN_HEIGHT = 240,
   parameter int MAX_BURST     = 64
) (
   input  logic                 iClk,
   input  logic                 iReset,
   pixel_port_arbiter_if.slave  bus
);
   localparam int XW = coord_w(SCREEN_WIDTH);
   localparam int YW = coord_w(SCREEN_HEIGHT);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

   state_t               r_state;
   logic [NUM_REQ-1:0]   r_grant;
   logic [1:0]           r_last;
   logic [CW-1:0]        r_cnt;
   logic [XW-1:0]        r_x;
   logic [YW-1:0]        r_y;
   logic [COLOUR_W-1:0]  r_colour;
   logic                 r_plot;
   logic                 r_busy;

   logic [NUM_REQ-1:0]   w_pick;
   logic [NUM_REQ-1:0]   w_accept;
   logic                 w_own_req;
   logic                 w_other_req;
   logic                 w_preempt;
   logic [1:0]           w_owner;
   logic [XW-1:0]        w_x;
   logic [YW-1:0]        w_y;
   logic [COLOUR_W-1:0]  w_colour;

   rr_pick3 u_pick (
      .req  (bus.iReq),
      .last (r_last),
      .pick (w_pick)
   );

   assign w_own_req   = |(r_grant & bus.iReq);
   assign w_other_req = |(~r_grant & bus.iReq);
   // Preempting owner keeps its pixel: the accept is suppressed in that cycle.
   assign w_preempt   = (r_state == OWN) && (r_cnt == CNT_MAX) && w_other_req;
   assign w_accept    = r_grant & bus.iValid & {NUM_REQ{~w_preempt}};

   always_comb begin
      w_owner = 2'd0;
      if (r_grant[REQ_RAM])    w_owner = 2'd1;
      if (r_grant[REQ_CURSOR]) w_owner = 2'd2;
   end

   always_comb begin
      w_x      = '0;
      w_y      = '0;
      w_colour = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_accept[i]) begin
            w_x      = w_x      | bus.iX[i*XW +: XW];
            w_y      = w_y      | bus.iY[i*YW +: YW];
            w_colour = w_colour | bus.iColour[i*COLOUR_W +: COLOUR_W];
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         r_state  <= IDLE;
         r_grant  <= '0;
         r_last   <= 2'd2;
         r_cnt    <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_colour <= '0;
         r_plot   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_plot <= |w_accept;
         if (|w_accept) begin
            r_x      <= w_x;
            r_y      <= w_y;
            r_colour <= w_colour;
         end
         case (r_state)
            IDLE: begin
               if (|bus.iReq) begin
                  r_grant <= w_pick;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= OWN;
               end
            end
            OWN: begin
               if (|w_accept && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
               if (!w_own_req || w_preempt) begin
                  r_last  <= w_owner;
                  r_grant <= '0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.oGrant   = r_grant;
   assign bus.oAccept  = w_accept;
   assign bus.oX_pixel = r_x;
   assign bus.oY_pixel = r_y;
   assign bus.oColour  = r_colour;
   assign bus.oPlot    = r_plot;
   assign bus.oBusy    = r_busy;
endmodule
